medac_win_sweep_ctrl: RTL and testbench

// - Calibration sequencer for the MEDAC-protected async FIFO test setup.
// - Steps the sync window select (win_sel) from win_lo to win_hi. For each setting it:
//     1. waits a settle period,
//     2. gates the MEDAC/FIFO start for a fixed measurement window,
//     3. reads the 32-bit pointer-error counter,
//     4. keeps the window with the fewest errors.
// - Sits beside the FIFO/MEDAC top. Drives its win_sel and start; reads its error_ptr_cnt.

---
 rtl/medac_win_sweep_ctrl.sv | 161 ++++++++++++++++
 tb/tb_medac_win_sweep_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/medac_win_sweep_ctrl.sv
// Window-select calibration sweep for the MEDAC-protected async FIFO: settle, measure, drain, evaluate.
// Optional build macro SWEEP_EARLY_EXIT_EN: stop the sweep at the first window with zero errors.
module medac_win_sweep_ctrl #(
  parameter int CNT_W         = 32,
  parameter int WIN_W         = 4,
  parameter int SETTLE_CYCLES = 16,
  parameter int MEAS_CYCLES   = 1024,
  parameter int DRAIN_CYCLES  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_go,
  input  logic             i_abort,
  input  logic [WIN_W-1:0] i_win_lo,
  input  logic [WIN_W-1:0] i_win_hi,
  input  logic [CNT_W-1:0] i_err_cnt,
  output logic [WIN_W-1:0] o_win_sel,
  output logic             o_start,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_cfg_err,
  output logic [WIN_W-1:0] o_best_win,
  output logic [CNT_W-1:0] o_best_err
);

  localparam logic [31:0] SETTLE_LD = 32'(SETTLE_CYCLES - 1);
  localparam logic [31:0] MEAS_LD   = 32'(MEAS_CYCLES - 1);
  localparam logic [31:0] DRAIN_LD  = 32'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_MEASURE, S_DRAIN, S_EVAL, S_DONE
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [31:0]      r_cnt;
  logic [31:0]      w_cnt_load;
  logic [WIN_W-1:0] r_hi;
  logic [WIN_W-1:0] r_win_sel;
  logic [WIN_W-1:0] r_best_win;
  logic [CNT_W-1:0] r_best_err;
  logic [CNT_W-1:0] r_snap;
  logic             r_start;
  logic             r_busy;
  logic             r_done;
  logic             r_cfg_err;
  logic [CNT_W-1:0] w_delta;
  logic             w_better;
  logic             w_cnt_zero;
  logic             w_go_ok;
  logic             w_go_bad;
  logic             w_last;

  always_comb begin
    w_state_next = r_state;
    w_cnt_load   = '0;
    // Modular subtraction gives the right delta across a counter wrap.
    w_delta      = i_err_cnt - r_snap;
    w_better     = (w_delta < r_best_err);
    w_cnt_zero   = (r_cnt == '0);
    w_go_ok      = i_go && !i_abort && (i_win_lo <= i_win_hi);
    w_go_bad     = i_go && !i_abort && (i_win_lo > i_win_hi);
`ifdef SWEEP_EARLY_EXIT_EN
    w_last       = (r_win_sel == r_hi) || (w_delta == '0);
`else
    w_last       = (r_win_sel == r_hi);
`endif
    case (r_state)
      S_IDLE:    if (w_go_ok) w_state_next = S_SETTLE;
      S_SETTLE:  if (w_cnt_zero) w_state_next = S_MEASURE;
      S_MEASURE: if (w_cnt_zero) w_state_next = S_DRAIN;
      S_DRAIN:   if (w_cnt_zero) w_state_next = S_EVAL;
      S_EVAL:    w_state_next = w_last ? S_DONE : S_SETTLE;
      S_DONE:    w_state_next = S_IDLE;
      default:   w_state_next = S_IDLE;
    endcase
    if (i_abort && (r_state != S_IDLE)) begin
      w_state_next = S_IDLE;
    end
    case (w_state_next)
      S_SETTLE:  w_cnt_load = SETTLE_LD;
      S_MEASURE: w_cnt_load = MEAS_LD;
      S_DRAIN:   w_cnt_load = DRAIN_LD;
      default:   w_cnt_load = '0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != r_state) begin
        r_cnt <= w_cnt_load;
      end else if (!w_cnt_zero) begin
        r_cnt <= r_cnt - 32'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_hi       <= '0;
      r_win_sel  <= '0;
      r_best_win <= '0;
      r_best_err <= '1;
      r_snap     <= '0;
      r_start    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_cfg_err  <= 1'b0;
    end else begin
      // start and busy follow the next state so they line up exactly with the state they describe.
      r_start <= (w_state_next == S_MEASURE);
      r_busy  <= (w_state_next != S_IDLE);
      r_done  <= 1'b0;
      if ((r_state == S_SETTLE) && w_cnt_zero) begin
        r_snap <= i_err_cnt;
      end
      case (r_state)
        S_IDLE: begin
          if (w_go_ok) begin
            r_hi       <= i_win_hi;
            r_win_sel  <= i_win_lo;
            r_best_win <= i_win_lo;
            r_best_err <= '1;
            r_cfg_err  <= 1'b0;
          end else if (w_go_bad) begin
            r_cfg_err <= 1'b1;
            r_done    <= 1'b1;
          end
        end
        S_EVAL: begin
          if (!i_abort) begin
            if (w_better) begin
              r_best_win <= r_win_sel;
              r_best_err <= w_delta;
            end
            if (!w_last) begin
              r_win_sel <= r_win_sel + 1'b1;
            end
          end
        end
        S_DONE: begin
          if (!i_abort) r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_win_sel  = r_win_sel;
  assign o_start    = r_start;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_cfg_err  = r_cfg_err;
  assign o_best_win = r_best_win;
  assign o_best_err = r_best_err;

endmodule

// File: tb/tb_medac_win_sweep_ctrl.sv
// Scoreboard bench for medac_win_sweep_ctrl: stimulus queues expected results, negedge monitor compares.
module tb_medac_win_sweep_ctrl;

  localparam int SETTLE = 2;
  localparam int MEAS   = 8;
  localparam int DRAIN  = 1;
  localparam int WINC   = SETTLE + MEAS + DRAIN + 1;

  logic        clk;
  logic        rst;
  logic        go;
  logic        abort;
  logic [3:0]  win_lo;
  logic [3:0]  win_hi;
  logic [31:0] err_cnt;
  logic [3:0]  win_sel;
  logic        start;
  logic        busy;
  logic        done;
  logic        cfg_err;
  logic [3:0]  best_win;
  logic [31:0] best_err;

  medac_win_sweep_ctrl #(
    .CNT_W(32), .WIN_W(4),
    .SETTLE_CYCLES(SETTLE), .MEAS_CYCLES(MEAS), .DRAIN_CYCLES(DRAIN)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_go(go), .i_abort(abort),
    .i_win_lo(win_lo), .i_win_hi(win_hi), .i_err_cnt(err_cnt),
    .o_win_sel(win_sel), .o_start(start), .o_busy(busy), .o_done(done),
    .o_cfg_err(cfg_err), .o_best_win(best_win), .o_best_err(best_err)
  );

  typedef struct {
    logic [3:0]  win;
    logic [31:0] err;
    logic        cfg;
    int          lat;
    int          starts;
  } exp_t;

  typedef struct {
    string       nm;
    logic [63:0] act;
    logic [63:0] exp_v;
  } dchk_t;

  exp_t  sb_q[$];
  dchk_t dq[$];

  int          checks;
  int          errors;
  int          cyc;
  int          inc[16];
  logic [31:0] err_base;
  logic [31:0] err_acc;
  logic [3:0]  exp_lo;
  logic [3:0]  exp_hi;

  assign err_cnt = err_base + err_acc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Error-counter model: each window's increment lands when start rises.
  int   m_idx;
  logic m_prev;
  initial begin
    err_acc = '0;
    m_idx   = 0;
    m_prev  = 1'b0;
  end
  always @(negedge clk) begin
    if (go) m_idx = 0;
    if (start && !m_prev) begin
      if (m_idx < 16) err_acc = err_acc + 32'(inc[m_idx]);
      m_idx++;
    end
    m_prev = start;
  end

  // Monitor: direct checks queued by stimulus, window-range/start-run checks, and done scoreboard.
  int   start_cnt;
  int   run;
  int   go_cyc;
  logic prev_start;
  initial begin
    checks = 0; errors = 0; start_cnt = 0; run = 0; go_cyc = 0; prev_start = 1'b0;
  end
  always @(negedge clk) begin
    while (dq.size() > 0) begin
      dchk_t d;
      d = dq.pop_front();
      chk(d.nm, d.act, d.exp_v);
    end
    if (rst) begin
      start_cnt  = 0;
      run        = 0;
      prev_start = 1'b0;
    end else begin
      if (go) begin
        start_cnt = 0;
        go_cyc    = cyc;
      end
      if (start) begin
        start_cnt++;
        run++;
      end else begin
        if (prev_start && busy) chk("start_run", 64'(run), 64'(MEAS));
        run = 0;
      end
      if (busy) chk("win_range", 64'((win_sel >= exp_lo) && (win_sel <= exp_hi)), 64'd1);
      if (done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 64'(done), 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          $display("sweep done: best_win=%0d best_err=%0h cfg_err=%0b lat=%0d starts=%0d",
                   best_win, best_err, cfg_err, cyc - go_cyc, start_cnt);
          chk("best_win", 64'(best_win), 64'(e.win));
          chk("best_err", 64'(best_err), 64'(e.err));
          chk("cfg_err",  64'(cfg_err),  64'(e.cfg));
          chk("latency",  64'(cyc - go_cyc), 64'(e.lat));
          chk("start_cycles", 64'(start_cnt), 64'(e.starts));
        end
        start_cnt = 0;
      end
      prev_start = start;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dchk(input string nm, input logic [63:0] a, input logic [63:0] e);
    dq.push_back('{nm, a, e});
  endtask

  task automatic expect_sweep(input logic [3:0] w, input logic [31:0] e, input logic c,
                              input int lat, input int st);
    sb_q.push_back('{w, e, c, lat, st});
  endtask

  task automatic issue_go(input logic [3:0] lo, input logic [3:0] hi);
    exp_lo = lo;
    exp_hi = hi;
    win_lo = lo;
    win_hi = hi;
    go     = 1'b1;
    tick();
    go     = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int max_cyc);
    int n;
    n = 0;
    while (!done && n < max_cyc) begin
      tick();
      n++;
    end
    dchk({nm, "_done_seen"}, 64'(done), 64'd1);
    tick();
  endtask

  task automatic set_incs(input int first3_0, input int first3_1, input int first3_2, input int rest);
    for (int i = 0; i < 16; i++) inc[i] = rest;
    inc[0] = first3_0;
    inc[1] = first3_1;
    inc[2] = first3_2;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; go = 1'b0; abort = 1'b0; win_lo = '0; win_hi = '0;
    err_base = '0; exp_lo = '0; exp_hi = '0;
    for (int i = 0; i < 16; i++) inc[i] = 0;
    repeat (3) tick();
    dchk("rst_win_sel",  64'(win_sel),  64'd0);
    dchk("rst_start",    64'(start),    64'd0);
    dchk("rst_busy",     64'(busy),     64'd0);
    dchk("rst_done",     64'(done),     64'd0);
    dchk("rst_cfg_err",  64'(cfg_err),  64'd0);
    dchk("rst_best_win", 64'(best_win), 64'd0);
    dchk("rst_best_err", 64'(best_err), 64'hFFFF_FFFF);
    rst = 1'b0;
    tick();

    // T1: lo=2..5, deltas 3,1,1,4 -> window 3 wins the tie with window 4.
    set_incs(3, 1, 1, 4);
    inc[3] = 4;
    expect_sweep(4'd3, 32'd1, 1'b0, 1 + 4 * WINC + 1, 4 * MEAS);
    issue_go(4'd2, 4'd5);
    dchk("t1_busy", 64'(busy), 64'd1);
    dchk("t1_win_sel", 64'(win_sel), 64'd2);
    wait_done("t1", 200);
    dchk("t1_busy_after", 64'(busy), 64'd0);

    // T2: counter wraps from FFFF_FFFE to 0000_0001 within one window.
    set_incs(3, 0, 0, 0);
    err_base = 32'hFFFF_FFFE - err_acc;
    tick();
    expect_sweep(4'd7, 32'd3, 1'b0, 1 + WINC + 1, MEAS);
    issue_go(4'd7, 4'd7);
    wait_done("t2", 100);
    dchk("t2_err_cnt_end", 64'(err_cnt), 64'h1);

    // T3: lo > hi rejected; best_* keep T2 results.
    expect_sweep(4'd7, 32'd3, 1'b1, 1, 0);
    issue_go(4'd9, 4'd4);
    dchk("t3_busy", 64'(busy), 64'd0);
    wait_done("t3", 10);
    repeat (3) tick();
    dchk("t3_cfg_sticky", 64'(cfg_err), 64'd1);
    dchk("t3_busy_idle", 64'(busy), 64'd0);
    dchk("t3_start_idle", 64'(start), 64'd0);

    // T4: abort during window 3 MEASURE, then restart from window 0.
    set_incs(1, 1, 1, 1);
    issue_go(4'd0, 4'd15);
    dchk("t4_cfg_cleared", 64'(cfg_err), 64'd0);
    begin
      int n;
      n = 0;
      while (!(win_sel == 4'd3 && start) && n < 300) begin
        tick();
        n++;
      end
    end
    dchk("t4_in_win3_meas", 64'(win_sel == 4'd3 && start), 64'd1);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    dchk("t4_abort_start", 64'(start), 64'd0);
    dchk("t4_abort_busy",  64'(busy),  64'd0);
    dchk("t4_abort_done",  64'(done),  64'd0);
    dchk("t4_abort_win",   64'(win_sel), 64'd3);
    repeat (4) tick();
    dchk("t4_no_done_later", 64'(done), 64'd0);
    issue_go(4'd0, 4'd15);
    dchk("t4_restart_win", 64'(win_sel), 64'd0);
    dchk("t4_restart_busy", 64'(busy), 64'd1);
    repeat (30) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    dchk("t4_abort2_busy", 64'(busy), 64'd0);

    // T5: top-of-range windows with zero errors; lowest window wins the tie.
    set_incs(0, 0, 0, 0);
`ifdef SWEEP_EARLY_EXIT_EN
    expect_sweep(4'd14, 32'd0, 1'b0, 1 + WINC + 1, MEAS);
`else
    expect_sweep(4'd14, 32'd0, 1'b0, 1 + 2 * WINC + 1, 2 * MEAS);
`endif
    issue_go(4'd14, 4'd15);
    wait_done("t5", 100);
    dchk("t5_win_sel_end", 64'(win_sel), 64'd15);

    // T6: zero-error window 2 inside a full 0..15 sweep.
    set_incs(5, 2, 0, 1);
`ifdef SWEEP_EARLY_EXIT_EN
    expect_sweep(4'd2, 32'd0, 1'b0, 1 + 3 * WINC + 1, 3 * MEAS);
`else
    expect_sweep(4'd2, 32'd0, 1'b0, 1 + 16 * WINC + 1, 16 * MEAS);
`endif
    issue_go(4'd0, 4'd15);
    wait_done("t6", 400);

    // Reset in the middle of a sweep returns every output to its reset value.
    set_incs(3, 1, 1, 4);
    issue_go(4'd2, 4'd5);
    repeat (20) tick();
    rst = 1'b1;
    tick();
    dchk("rst_mid_busy",     64'(busy),     64'd0);
    dchk("rst_mid_start",    64'(start),    64'd0);
    dchk("rst_mid_win_sel",  64'(win_sel),  64'd0);
    dchk("rst_mid_best_win", 64'(best_win), 64'd0);
    dchk("rst_mid_best_err", 64'(best_err), 64'hFFFF_FFFF);
    rst = 1'b0;
    repeat (3) tick();

    dchk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
